// File: rtl/brcomp_pkg.sv
// Shared types for the branch-comparator arbiter.
// Optional statistics counters are enabled with the BRCOMP_ARB_STATS_EN macro.
package brcomp_pkg;

    localparam int unsigned NUM_PORTS = 2;
    localparam int unsigned DEFAULT_WIDTH = 16;

    // Compare request as issued by a requester (default operand width)
    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] rs1;
        logic [DEFAULT_WIDTH-1:0] rs2;
        logic                     unsigned_cmp;
    } cmp_req_t;

    // Compare result
    typedef struct packed {
        logic less;
        logic equal;
    } cmp_rsp_t;

    typedef enum logic [0:0] {
        StIdle,
        StResp
    } arb_state_e;

endpackage

// File: rtl/brcmp_core.sv
// Purely combinational WIDTH-bit branch comparator (signed/unsigned less, equal).
module brcmp_core
    import brcomp_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic             unsigned_i,
    output cmp_rsp_t         rsp_o
);

    logic [WIDTH:0] diff;

    // Subtract at WIDTH+1 bits so the top bit is the unsigned borrow
    always_comb begin
        diff        = {1'b0, rs1_i} - {1'b0, rs2_i};
        rsp_o.equal = (rs1_i == rs2_i);
        if (unsigned_i) begin
            rsp_o.less = diff[WIDTH];
        end else if (rs1_i[WIDTH-1] != rs2_i[WIDTH-1]) begin
            // Differing signs: the negative operand is the smaller one
            rsp_o.less = rs1_i[WIDTH-1];
        end else begin
            rsp_o.less = diff[WIDTH-1];
        end
    end

endmodule

// File: rtl/brcomp_arb.sv
// Two-port round-robin arbiter sharing one branch comparator.
// Define BRCOMP_ARB_STATS_EN to add saturating grant/stall counters.
module brcomp_arb
    import brcomp_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              req_valid_i,
    output logic [NUM_PORTS-1:0]              req_ready_o,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]   rs1_data_i,
    input  logic [NUM_PORTS-1:0][WIDTH-1:0]   rs2_data_i,
    input  logic [NUM_PORTS-1:0]              br_unsigned_i,
    output logic [NUM_PORTS-1:0]              rsp_valid_o,
    input  logic [NUM_PORTS-1:0]              rsp_ready_i,
    output logic                              br_less_o,
    output logic                              br_equal_o
`ifdef BRCOMP_ARB_STATS_EN
    ,
    output logic [NUM_PORTS-1:0][CNT_W-1:0]   grant_cnt_o,
    output logic [CNT_W-1:0]                  stall_cnt_o
`endif
);

    arb_state_e           state_q;
    logic                 own_q;
    logic                 last_q;
    logic                 less_q;
    logic                 equal_q;

    logic                 free;
    logic [NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0] accept;
    logic                 accept_any;
    logic                 sel;
    cmp_rsp_t             cmp_rsp;

    // Slot availability and round-robin grant; last_q loses a tie
    always_comb begin
        free = (state_q == StIdle) || ((state_q == StResp) && rsp_ready_i[own_q]);
        case (req_valid_i)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        req_ready_o = free ? grant : 2'b00;
        accept      = req_valid_i & req_ready_o;
        accept_any  = |accept;
        sel         = grant[1];
    end

    brcmp_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .rs1_i      (rs1_data_i[sel]),
        .rs2_i      (rs2_data_i[sel]),
        .unsigned_i (br_unsigned_i[sel]),
        .rsp_o      (cmp_rsp)
    );

    // Response valid is steered to the owner only
    always_comb begin
        rsp_valid_o = 2'b00;
        if (state_q == StResp) begin
            rsp_valid_o[own_q] = 1'b1;
        end
    end

    assign br_less_o  = less_q;
    assign br_equal_o = equal_q;

    // Arbiter FSM with registered result; an accept overrides the handshake drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
        end else if (accept_any) begin
            state_q <= StResp;
            own_q   <= accept[1];
            last_q  <= accept[1];
            less_q  <= cmp_rsp.less;
            equal_q <= cmp_rsp.equal;
        end else if ((state_q == StResp) && rsp_ready_i[own_q]) begin
            state_q <= StIdle;
        end
    end

`ifdef BRCOMP_ARB_STATS_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] grant_cnt_q;
    logic [CNT_W-1:0]                stall_cnt_q;

    // Saturating per-port accept counters and contention/stall counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int n = 0; n < NUM_PORTS; n++) begin
                if (accept[n] && (grant_cnt_q[n] != {CNT_W{1'b1}})) begin
                    grant_cnt_q[n] <= grant_cnt_q[n] + 1'b1;
                end
            end
            if ((|req_valid_i) && !accept_any && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = |CNT_W;
`endif

endmodule
